// File: rtl/lte_dl_gain_pkg.sv
// Shared types and constants for the LTE downlink AGC gain ramp controller.
package lte_dl_gain_pkg;

  localparam int          XNUM_DEF   = 8;
  localparam int          GAIN_W     = 16;
  localparam logic [15:0] GAIN_UNITY = 16'h4000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    STEP    = 2'd2,
    COMMIT  = 2'd3
  } gain_state_e;

  // Build a 32-bit antenna word from its pass-through half and gain field.
  function automatic logic [31:0] ant_pack(input logic [31-GAIN_W:0] hi,
                                           input logic [GAIN_W-1:0]  gain);
    return {hi, gain};
  endfunction

  // Gain field of a 32-bit antenna word.
  function automatic logic [GAIN_W-1:0] ant_gain(input logic [31:0] word);
    return word[GAIN_W-1:0];
  endfunction

  // Pass-through field of a 32-bit antenna word.
  function automatic logic [31-GAIN_W:0] ant_hi(input logic [31:0] word);
    return word[31:GAIN_W];
  endfunction

endpackage

// File: rtl/lte_gain_step_unit.sv
// Bounded gain step: moves cur toward tgt by at most step, or jumps when forced.
module lte_gain_step_unit
  import lte_dl_gain_pkg::*;
#(
  parameter int GAIN_W = lte_dl_gain_pkg::GAIN_W
) (
  input  logic [GAIN_W-1:0] cur,
  input  logic [GAIN_W-1:0] tgt,
  input  logic [GAIN_W-1:0] step,
  input  logic              frc,
  output logic [GAIN_W-1:0] next
);

  logic              up;
  logic [GAIN_W-1:0] diff;

  // Distance is taken unsigned in the right direction, so a step is only
  // applied when it is strictly smaller than the gap: no overshoot, no wrap.
  always_comb begin
    up   = tgt > cur;
    diff = up ? (tgt - cur) : (cur - tgt);
    next = tgt;
    if (!frc && (diff > step)) begin
      next = up ? (cur + step) : (cur - step);
    end
  end

endmodule

// File: rtl/lte_dl_gain_ramp_ctrl.sv
// Frame-aligned per-antenna gain ramp for the LTE downlink AGC gain input.
module lte_dl_gain_ramp_ctrl
  import lte_dl_gain_pkg::*;
#(
  parameter int                 XNUM     = XNUM_DEF,
  parameter int                 GAIN_W   = lte_dl_gain_pkg::GAIN_W,
  parameter logic [GAIN_W-1:0]  GAIN_RST = GAIN_UNITY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_fram_hd,
  input  logic                 i_enable,
  input  logic                 i_force,
  input  logic [GAIN_W-1:0]    i_ramp_step,
  input  logic [XNUM*32-1:0]   i_gain_tgt,
  output logic [XNUM*32-1:0]   o_gain_cur,
  output logic                 o_busy,
  output logic                 o_upd,
  output logic                 o_settled
);

  localparam int IDX_W = (XNUM > 1) ? $clog2(XNUM) : 1;

  gain_state_e       state;
  logic [IDX_W-1:0]  idx;
  logic              force_pend;
  logic              frc_q;
  logic [31:0]       tgt_q    [XNUM];
  logic [GAIN_W-1:0] sh       [XNUM];
  logic [31:0]       gain_cur [XNUM];
  logic [GAIN_W-1:0] step_next;
  logic              all_eq;

  // Single step unit, time-shared across antennas by idx.
  lte_gain_step_unit #(
    .GAIN_W (GAIN_W)
  ) u_step (
    .cur  (ant_gain(gain_cur[idx])),
    .tgt  (ant_gain(tgt_q[idx])),
    .step (i_ramp_step),
    .frc  (frc_q),
    .next (step_next)
  );

  // True when every shadow gain has reached its captured target.
  always_comb begin
    all_eq = 1'b1;
    for (int n = 0; n < XNUM; n++) begin
      if (sh[n] != ant_gain(tgt_q[n])) all_eq = 1'b0;
    end
  end

  // Sequencer: capture, step each antenna into its shadow, commit all at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      force_pend <= 1'b0;
      frc_q      <= 1'b0;
      o_busy     <= 1'b0;
      o_upd      <= 1'b0;
      o_settled  <= 1'b0;
      for (int n = 0; n < XNUM; n++) gain_cur[n] <= ant_pack('0, GAIN_RST);
    end else begin
      o_upd <= 1'b0;
      if (i_force) force_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (i_fram_hd && i_enable) state <= CAPTURE;
        end
        CAPTURE: begin
          // A force pulse landing here belongs to the next sequence.
          frc_q      <= force_pend;
          force_pend <= i_force;
          idx        <= '0;
          o_busy     <= 1'b1;
          state      <= STEP;
        end
        STEP: begin
          if (idx == IDX_W'(XNUM - 1)) state <= COMMIT;
          else                         idx   <= idx + IDX_W'(1);
        end
        COMMIT: begin
          for (int n = 0; n < XNUM; n++) gain_cur[n] <= ant_pack(ant_hi(tgt_q[n]), sh[n]);
          o_upd     <= 1'b1;
          o_settled <= all_eq;
          o_busy    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Target snapshot and shadow gains; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == CAPTURE) begin
      for (int n = 0; n < XNUM; n++) tgt_q[n] <= i_gain_tgt[32*n +: 32];
    end
    if (state == STEP) begin
      sh[idx] <= step_next;
    end
  end

  for (genvar n = 0; n < XNUM; n++) begin : g_out
    assign o_gain_cur[32*n +: 32] = gain_cur[n];
  end

endmodule

// File: doc/lte_dl_gain_ramp_ctrl.md
Name: lte_dl_gain_ramp_ctrl

Overview:
- Configures the LTE downlink AGC stage, the data_path_agc instance with XNUM=8.
- Takes per-antenna target gains from registers and moves the live gain toward each target by at most a programmed step per radio frame.
- Updates are applied atomically, aligned to the frame header. This avoids gain steps inside a frame and keeps the 8 antennas coherent.
- Sits between the register interface and the i_ddc_gain_lte input of the AGC.

Parameters:
- XNUM, 8, number of antennas / gain words.
- GAIN_W, 16, width of the active gain field (unsigned Q2.14 linear gain).
- GAIN_RST, 16'h4000, reset value of every active gain field (unity).

Ports:
- clk  in  1  datapath clock (245.76 MHz); the only clock.
- rst  in  1  reset, synchronous, active-high.
- i_fram_hd  in  1  one-cycle frame header pulse, same source as the AGC input frame header.
- i_enable  in  1  level; when low, no new update sequence starts.
- i_force  in  1  one-cycle pulse; the next sequence loads targets directly, with no ramp.
- i_ramp_step  in  GAIN_W  maximum gain change per frame per antenna.
- i_gain_tgt  in  XNUM*32  target words; antenna n uses bits [32n+31:32n]. Bits [15:0] are gain, [31:16] pass through.
- o_gain_cur  out  XNUM*32  live gain bus to the AGC, same packing as i_gain_tgt.
- o_busy  out  1  high while an update sequence runs.
- o_upd  out  1  one-cycle pulse on the cycle o_gain_cur changes.
- o_settled  out  1  high when every antenna's live gain equals the target captured for it.

Behaviour:
- Reset (synchronous; rst high at a rising edge):
  - Each o_gain_cur word = {16'd0, GAIN_RST}.
  - o_busy = 0, o_upd = 0, o_settled = 0, FSM = IDLE, force_pend = 0.
- force_pend: set by i_force in any state. It is consumed (cleared) in CAPTURE. An i_force pulse coincident with CAPTURE is retained for the next sequence.
- FSM states: IDLE, CAPTURE, STEP, COMMIT.
  - IDLE -> CAPTURE when i_fram_hd && i_enable.
  - CAPTURE:
    - Snapshot i_gain_tgt into tgt_q.
    - Latch force_pend into frc_q, then clear force_pend.
    - idx = 0; o_busy = 1.
  - STEP: one antenna per cycle, idx 0..XNUM-1.
    - Compute the next value into the shadow register sh[idx].
    - After idx = XNUM-1, go to COMMIT.
  - COMMIT:
    - o_gain_cur <= {tgt_q[n][31:16], sh[n]} for all n, in the same edge.
    - o_upd = 1 for this cycle.
    - o_settled = (sh == tgt_q[15:0] for all n).
    - Then go to IDLE; o_busy = 0.
- Latency: i_fram_hd sampled at edge E -> o_gain_cur updated at edge E+XNUM+2 (E+10 for XNUM=8). o_upd is high in the following cycle.
- Step arithmetic (unsigned, GAIN_W bits, computed at full width):
  - frc_q = 1 -> sh = tgt.
  - Otherwise, with d = |tgt - cur|:
    - d <= step -> sh = tgt.
    - tgt > cur -> sh = cur + step.
    - else -> sh = cur - step.
  - The result never overshoots and never wraps.
  - i_ramp_step = 0 with no force -> gain holds. o_upd still pulses; o_settled reflects the comparison.
- Boundary conditions:
  - i_fram_hd while not in IDLE: ignored. No queueing, no error flag.
  - i_enable deasserted mid-sequence: the sequence completes. Only the start is gated.
  - i_gain_tgt changing mid-sequence: no effect; only the CAPTURE snapshot is used.
  - rst mid-sequence: sequence aborted; outputs take reset values on that edge.
  - o_gain_cur is constant outside the COMMIT edge.

Decomposition:
- Package lte_dl_gain_pkg:
  - state enum (IDLE/CAPTURE/STEP/COMMIT);
  - GAIN_W and a GAIN_UNITY constant (16'h4000);
  - XNUM default;
  - a function to extract/pack the 32-bit antenna word.
- Sub-module lte_gain_step_unit: combinational; inputs cur, tgt, step, force; output next per the step arithmetic. Instantiated once and time-shared via idx.

Test Plan:
- Reset: assert rst 2 cycles -> all o_gain_cur words = 32'h0000_4000; o_busy = 0, o_settled = 0, o_upd = 0.
- Up-ramp: all targets 16'h4100, step 16'h0040, enable = 1, 4 frame headers -> gains 4040, 4080, 40C0, 4100. o_settled = 1 only after the 4th commit. Each update lands at fram_hd + 10 cycles.
- Down-ramp, non-multiple: ant3 target 16'h3F90 from 4000, step 16'h0040 -> 3FC0 then 3F90 (clamped). Other antennas unchanged. Bits [31:16] = 16'hA5A5 passthrough appear at the first commit.
- Force: step 16'h0001, i_force pulse, target 16'h2000 -> 2000 on the next commit. The following frame ramps normally (frc_q cleared).
- Collision: i_fram_hd again 3 cycles after the first -> exactly one o_upd pulse.
- Mid-operation: rst mid-STEP -> reset values, state IDLE. Then i_enable = 0 at a header -> no o_upd and o_busy stays low.
